// File: rtl/tohost_reader.sv
// -----------------------------------------------------------------------------
// tohost_reader
//   Snoops committed CSR (tohost) writes, queues each written value in a small
//   circular FIFO and drains it to the host over a valid/ready handshake.
//   Optionally decodes the RISC-V tohost completion convention into sticky
//   done/pass/fail_code status.
//
// Build option:
//   TOHOST_DONE_DECODE_EN - when defined, the completion decode state machine
//                           and done/pass/fail_code registers are built; when
//                           undefined those outputs are tied to 0.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CW     count width, log2(DEPTH)+1
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   stall       in   pipeline stall; writes commit only when low
//   csr_we      in   CSR write enable
//   wb_data     in   value written to tohost
//   host_valid  out  FIFO head valid
//   host_data   out  FIFO head value (0 when empty)
//   host_ready  in   host accepts head this cycle
//   count       out  FIFO occupancy 0..DEPTH
//   overflow    out  sticky: a committed write was dropped
//   done        out  sticky: completion write seen
//   pass        out  completion value was exactly 1
//   fail_code   out  completion value >> 1
//
// FSM states:
//   state  | meaning
//   S_IDLE | no completion write seen yet
//   S_DONE | completion latched; absorbing until reset
// -----------------------------------------------------------------------------
module tohost_reader #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          csr_we,
  input  logic [31:0]   wb_data,
  output logic          host_valid,
  output logic [31:0]   host_data,
  input  logic          host_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          done,
  output logic          pass,
  output logic [30:0]   fail_code
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_commit;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count_nxt;

  assign w_commit = csr_we & ~stall;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = ~w_empty & host_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push   = w_commit & (~w_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is deliberately not reset; host_data masks it while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      if (w_commit && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign host_valid = ~w_empty;
  assign host_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign count      = r_count;
  assign overflow   = r_overflow;

`ifdef TOHOST_DONE_DECODE_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_latch;
  logic        r_pass;
  logic [30:0] r_fail_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decode runs on every commit, whether or not the FIFO had room.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit && wb_data[0]) begin
          w_state_nxt = S_DONE;
          w_latch     = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass      <= 1'b0;
      r_fail_code <= '0;
    end else if (w_latch) begin
      r_pass      <= (wb_data == 32'h1);
      r_fail_code <= wb_data[31:1];
    end
  end

  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
`else
  assign done      = 1'b0;
  assign pass      = 1'b0;
  assign fail_code = '0;
`endif

endmodule
